camera_capture: RTL and testbench
=================================

Name: camera_capture

Overview:
- Pixel-capture front end for the OV7670-style camera port, clocked by the camera pixel clock.
- Frame-synchronises on v_sync and assembles RGB565 byte pairs gated by h_ref.
- Emits one 3-bit rgb pixel per valid pair, with a linear frame-buffer write address, pixel coordinates and frame pulses.
- Feeds the frame buffer and VGA readout downstream; sits directly behind the sensor pins.

Parameters:
- H_PIXELS, 640: active pixels per sensor line.
- V_LINES, 480: active lines per frame.
- ADDR_W, 19: width of the write address; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES.

Ports:
- pclk  in  1: camera pixel clock; all inputs are sampled on its rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- data_in  in  8: camera data byte.
- h_ref  in  1: high while line bytes are valid.
- v_sync  in  1: high during vertical blanking.
- enable  in  1: arms capture; level-sensitive.
- pixel_out  out  3: {R[4], G[5], B[4]} of the RGB565 pixel.
- pixel_valid  out  1: one-cycle write strobe for pixel_out/pixel_addr.
- pixel_addr  out  ADDR_W: linear address y*H_PIXELS+x.
- x_count  out  10: column of the emitted pixel.
- y_count  out  10: current line.
- frame_start  out  1: one-cycle pulse at start of the active frame.
- frame_done  out  1: one-cycle pulse at end of frame.
- overrun  out  1: sticky error flag; cleared at frame_start.

Behaviour:
- Reset state: every output 0, FSM in IDLE, byte phase 0, v_sync_q/h_ref_q 0.
- Reset mid-frame aborts immediately; no frame_done is issued.
- FSM IDLE: if enable=1, go to WAIT_VS_HIGH.
- FSM WAIT_VS_HIGH: waits for the v_sync level high, not an edge, so a sync already high at reset is still caught. Then go to WAIT_VS_LOW.
- FSM WAIT_VS_LOW: on v_sync low, pulse frame_start the next cycle. Clear x, y, address and overrun; go to ACTIVE.
- FSM ACTIVE, pixel assembly:
  - Each cycle with h_ref=1 toggles the byte phase.
  - Phase 0 latches the first byte (RRRRRGGG).
  - Phase 1 forms the pixel from the latched byte plus the current byte (GGGBBBBB).
  - pixel_valid, pixel_out, pixel_addr and x_count are registered one cycle after the second byte is sampled (latency 1).
- FSM ACTIVE, end of line (h_ref falling edge, detected via h_ref_q):
  - Byte phase forced to 0.
  - x reset to 0.
  - y increments only if the line emitted at least one pixel.
  - An odd trailing byte is dropped and sets overrun.
- FSM ACTIVE, end of frame:
  - v_sync rising edge: frame_done pulses the next cycle.
  - If enable=1, go to WAIT_VS_LOW; otherwise go to IDLE.
  - If h_ref is high in the same cycle, line-end handling happens first, and any in-flight pixel is still emitted.
- Enable deasserted mid-frame: the current frame completes; the FSM returns to IDLE after frame_done.
- Bounds:
  - Pixels with x >= H_PIXELS are not emitted and set overrun.
  - Lines with y >= V_LINES emit nothing and set overrun.
  - The address never exceeds H_PIXELS*V_LINES-1.
- Address is an incremental counter (+1 per emitted pixel), not a multiplier; clears at frame_start.
- pixel_valid never asserts outside ACTIVE.

Optional Feature:
- Macro: CAPTURE_DECIMATE_EN.
- When defined:
  - Only pixels with even sensor x and even sensor y are emitted (320x240 from 640x480).
  - x_count, y_count and pixel_addr count kept pixels only.
  - Address range is (H_PIXELS/2)*(V_LINES/2).
  - Bounds checks still use sensor coordinates.
- When undefined: every pixel is emitted, as described above.

Decomposition:
- Package cam_pkg holds:
  - FSM state encoding (IDLE, WAIT_VS_HIGH, WAIT_VS_LOW, ACTIVE).
  - RGB565 field bit positions (R[15:11], G[10:5], B[4:0]).
  - Default H_PIXELS/V_LINES constants.
- Sub-module cam_pixel_pack:
  - Contents: byte-phase toggle, first-byte latch, odd-byte detection, 3-bit reduction.
  - Inputs: data_in, h_ref, h_ref_q.
  - Outputs: pix_stb, pix_rgb, odd_err.
- camera_capture keeps the sync FSM, counters, address and bounds logic.

Test Plan:
- Sync at reset: hold v_sync=1 through reset release with enable=1, drop v_sync after 10 cycles -> frame_start pulses exactly once, one cycle after the drop; no pixel_valid before that.
- Pixel format: stream 640x480 with every pair 0xF8,0x00 (pure red) -> 307200 strobes, pixel_out=3'b100, last pixel_addr=307199, frame_done one cycle after v_sync rises, overrun=0.
- Latency and colour: single line with pairs 0x07,0xE0 then 0x00,0x1F -> pixel_out=3'b010 at x=0, then 3'b001 at x=1, each pixel_valid one cycle after its second byte.
- Boundaries: 641 pixels on line 0, then a line with 3 bytes -> 640 strobes on line 0, third byte dropped, overrun=1, and overrun cleared at the next frame_start.
- Enable drop: deassert enable at line 100 -> frame completes to address 307199, frame_done pulses, FSM returns to IDLE, and no frame_start occurs on the next v_sync cycle.
- Decimation (CAPTURE_DECIMATE_EN): 640x480 frame with pixel value encoding x parity -> 76800 strobes, all from even x and even y, last pixel_addr=76799.

Source files
------------

// File: rtl/cam_pkg.sv
// cam_pkg: shared state encoding and RGB565 field positions for the
// OV7670 capture front end.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS_HIGH,
        WAIT_VS_LOW,
        ACTIVE
    } cam_state_t;

    localparam int CAM_H_PIXELS = 640;
    localparam int CAM_V_LINES  = 480;

    // MSB of each RGB565 field: R[15:11], G[10:5], B[4:0]
    localparam int RGB_R_MSB = 15;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_B_MSB = 4;

endpackage

// File: rtl/cam_pixel_pack.sv
// cam_pixel_pack: pairs sensor bytes into RGB565 words and reduces each
// word to a 3-bit pixel; flags a dangling first byte at line end.
module cam_pixel_pack
    import cam_pkg::*;
(
    input  logic       pclk,
    input  logic       reset_n,
    input  logic       i_active,
    input  logic       i_flush,
    input  logic [7:0] data_in,
    input  logic       h_ref,
    input  logic       h_ref_q,
    output logic       pix_stb,
    output logic [2:0] pix_rgb,
    output logic       odd_err
);

    logic        r_phase;
    logic [7:0]  r_byte0;
    logic [15:0] w_word;
    logic        w_line_end;
    logic        w_phase_nxt;
    logic        w_unused;

    assign w_word      = {r_byte0, data_in};
    assign w_line_end  = h_ref_q & ~h_ref;
    assign w_phase_nxt = r_phase ^ h_ref;
    assign pix_stb     = i_active & h_ref & r_phase;
    assign pix_rgb     = {w_word[RGB_R_MSB], w_word[RGB_G_MSB], w_word[RGB_B_MSB]};
    assign odd_err     = i_active & (w_line_end | i_flush) & w_phase_nxt;
    assign w_unused    = ^w_word;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= 1'b0;
            r_byte0 <= '0;
        end else begin
            if (!i_active || w_line_end || i_flush)
                r_phase <= 1'b0;
            else if (h_ref)
                r_phase <= ~r_phase;
            if (i_active && h_ref && !r_phase)
                r_byte0 <= data_in;
        end
    end

endmodule

// File: rtl/camera_capture.sv
// camera_capture: v_sync-locked OV7670 pixel capture with frame-buffer
// addressing; CAPTURE_DECIMATE_EN keeps only even-x/even-y pixels.
module camera_capture
    import cam_pkg::*;
#(
    parameter int H_PIXELS = CAM_H_PIXELS,
    parameter int V_LINES  = CAM_V_LINES,
    parameter int ADDR_W   = 19
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic [7:0]        data_in,
    input  logic              h_ref,
    input  logic              v_sync,
    input  logic              enable,
    output logic [2:0]        pixel_out,
    output logic              pixel_valid,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [9:0]        x_count,
    output logic [9:0]        y_count,
    output logic              frame_start,
    output logic              frame_done,
    output logic              overrun
);

    localparam logic [9:0]        LP_H  = 10'(H_PIXELS);
    localparam logic [9:0]        LP_V  = 10'(V_LINES);
    localparam logic [9:0]        LP_X1 = 10'd1;
    localparam logic [ADDR_W-1:0] LP_A1 = ADDR_W'(1);

    cam_state_t        r_state;
    cam_state_t        w_state_nxt;
    logic              r_vs_q;
    logic              r_href_q;
    logic [9:0]        r_sx;
    logic [9:0]        r_sy;
    logic [9:0]        r_ox;
    logic [9:0]        r_oy;
    logic [ADDR_W-1:0] r_addr;
    logic              r_line_px;
    logic              r_line_em;

    logic              w_active;
    logic              w_start;
    logic              w_frame_end;
    logic              w_eol;
    logic              w_stb;
    logic              w_odd_err;
    logic              w_in_bounds;
    logic              w_keep;
    logic              w_emit;
    logic [2:0]        w_rgb;

    cam_pixel_pack u_pack (
        .pclk     (pclk),
        .reset_n  (reset_n),
        .i_active (w_active),
        .i_flush  (w_frame_end),
        .data_in  (data_in),
        .h_ref    (h_ref),
        .h_ref_q  (r_href_q),
        .pix_stb  (w_stb),
        .pix_rgb  (w_rgb),
        .odd_err  (w_odd_err)
    );

    assign w_active    = (r_state == ACTIVE);
    // a frame end with h_ref still high closes the line in the same cycle
    assign w_eol       = w_active & ((r_href_q & ~h_ref) | (w_frame_end & h_ref));
    assign w_in_bounds = (r_sx < LP_H) && (r_sy < LP_V);
`ifdef CAPTURE_DECIMATE_EN
    assign w_keep      = ~r_sx[0] & ~r_sy[0];
`else
    assign w_keep      = 1'b1;
`endif
    assign w_emit      = w_stb & w_in_bounds & w_keep;
    assign y_count     = r_oy;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_frame_end = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (enable)
                    w_state_nxt = WAIT_VS_HIGH;
            end
            WAIT_VS_HIGH: begin
                if (v_sync)
                    w_state_nxt = WAIT_VS_LOW;
            end
            WAIT_VS_LOW: begin
                if (!v_sync) begin
                    w_start     = 1'b1;
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (v_sync && !r_vs_q) begin
                    w_frame_end = 1'b1;
                    w_state_nxt = enable ? WAIT_VS_LOW : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_q      <= 1'b0;
            r_href_q    <= 1'b0;
            r_sx        <= '0;
            r_sy        <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_addr      <= '0;
            r_line_px   <= 1'b0;
            r_line_em   <= 1'b0;
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
            pixel_addr  <= '0;
            x_count     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            r_vs_q      <= v_sync;
            r_href_q    <= h_ref;
            pixel_valid <= w_emit;
            frame_start <= w_start;
            frame_done  <= w_frame_end;

            if (w_emit) begin
                pixel_out  <= w_rgb;
                pixel_addr <= r_addr;
                x_count    <= r_ox;
                r_addr     <= r_addr + LP_A1;
                r_ox       <= r_ox + LP_X1;
                r_line_em  <= 1'b1;
            end

            if (w_stb) begin
                r_line_px <= 1'b1;
                if (r_sx < LP_H)
                    r_sx <= r_sx + LP_X1;
            end

            if ((w_stb && !w_in_bounds) || w_odd_err)
                overrun <= 1'b1;

            if (w_eol) begin
                r_sx      <= '0;
                r_ox      <= '0;
                r_line_px <= 1'b0;
                r_line_em <= 1'b0;
                if ((r_line_px || w_stb) && r_sy < LP_V)
                    r_sy <= r_sy + LP_X1;
                if (r_line_em || w_emit)
                    r_oy <= r_oy + LP_X1;
            end

            if (w_start) begin
                r_sx       <= '0;
                r_sy       <= '0;
                r_ox       <= '0;
                r_oy       <= '0;
                r_addr     <= '0;
                r_line_px  <= 1'b0;
                r_line_em  <= 1'b0;
                pixel_addr <= '0;
                x_count    <= '0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_camera_capture.sv
// tb_camera_capture: randomized stimulus, queue scoreboard and frame-level
// checks against a small arithmetic model of the capture rules.
module tb_camera_capture;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int AW = 7;
`ifdef CAPTURE_DECIMATE_EN
    localparam int NPIX   = (H / 2) * (V / 2);
    localparam int NLINES = V / 2;
`else
    localparam int NPIX   = H * V;
    localparam int NLINES = V;
`endif

    logic          pclk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    data_in = 8'h00;
    logic          h_ref = 1'b0;
    logic          v_sync = 1'b0;
    logic          enable = 1'b0;
    logic [2:0]    pixel_out;
    logic          pixel_valid;
    logic [AW-1:0] pixel_addr;
    logic [9:0]    x_count;
    logic [9:0]    y_count;
    logic          frame_start;
    logic          frame_done;
    logic          overrun;

    camera_capture #(
        .H_PIXELS (H),
        .V_LINES  (V),
        .ADDR_W   (AW)
    ) dut (
        .pclk        (pclk),
        .reset_n     (reset_n),
        .data_in     (data_in),
        .h_ref       (h_ref),
        .v_sync      (v_sync),
        .enable      (enable),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .pixel_addr  (pixel_addr),
        .x_count     (x_count),
        .y_count     (y_count),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [2:0] rgb;
        int         addr;
        int         x;
        int         y;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         pcnt = 0;
    int         fs_cnt = 0;
    int         fd_cnt = 0;
    int         pv_cnt = 0;
    int         fs_cyc = 0;
    int         fd_cyc = 0;
    int         last_addr = 0;
    logic [2:0] last_rgb = 3'b000;

    int         m_sy, m_oy, m_ox, m_addr;
    bit         m_ovr;
    logic [7:0] pat [4] = '{8'h07, 8'hE0, 8'h00, 8'h1F};

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endfunction

    function automatic logic [2:0] rgb3(logic [7:0] b0, logic [7:0] b1);
        logic [15:0] w;
        logic [4:0]  r;
        logic [5:0]  g;
        logic [4:0]  b;
        w = {b0, b1};
        r = w[15:11];
        g = w[10:5];
        b = w[4:0];
        return {r[4], g[5], b[4]};
    endfunction

    initial forever begin
        @(posedge pclk);
        pcnt++;
    end

    // monitor: pops the scoreboard whenever the DUT strobes a pixel
    initial forever begin
        exp_t e;
        @(negedge pclk);
        if (reset_n) begin
            if (frame_start) begin
                fs_cnt++;
                fs_cyc = pcnt;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = pcnt;
            end
            if (pixel_valid) begin
                pv_cnt++;
                last_addr = 32'(pixel_addr);
                last_rgb  = pixel_out;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel addr %0d x %0d", pixel_addr, x_count);
                end else begin
                    e = q.pop_front();
                    chk("pix_rgb", 32'(pixel_out), 32'(e.rgb));
                    chk("pix_addr", 32'(pixel_addr), e.addr);
                    chk("pix_x", 32'(x_count), e.x);
                    chk("pix_y", 32'(y_count), e.y);
                    chk("pix_latency", pcnt, e.cyc);
                end
            end
        end
    end

    task automatic drive(input logic hr, input logic vs, input logic [7:0] d);
        @(negedge pclk);
        h_ref  = hr;
        v_sync = vs;
        data_in = d;
    endtask

    task automatic send_line(input int nbytes, input int mode);
        logic [7:0] b;
        logic [7:0] b0;
        bit         em;
        bit         keep;
        int         j;
        exp_t       e;
        em   = 0;
        m_ox = 0;
        b0   = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            case (mode)
                1:       b = (i % 2 == 0) ? 8'hF8 : 8'h00;
                2:       b = pat[i % 4];
                default: b = 8'($urandom);
            endcase
            drive(1'b1, 1'b0, b);
            if (i % 2 == 0) begin
                b0 = b;
            end else begin
                j = i / 2;
`ifdef CAPTURE_DECIMATE_EN
                keep = (j % 2 == 0) && (m_sy % 2 == 0);
`else
                keep = 1;
`endif
                if (j < H && m_sy < V) begin
                    if (keep) begin
                        e.rgb  = rgb3(b0, b);
                        e.addr = m_addr;
                        e.x    = m_ox;
                        e.y    = m_oy;
                        e.cyc  = pcnt + 1;
                        q.push_back(e);
                        m_addr++;
                        m_ox++;
                        em = 1;
                    end
                end else begin
                    m_ovr = 1;
                end
            end
        end
        repeat (4) drive(1'b0, 1'b0, 8'($urandom));
        if (nbytes >= 2 && m_sy < V)
            m_sy++;
        if (em)
            m_oy++;
        if (nbytes % 2 == 1)
            m_ovr = 1;
    endtask

    task automatic start_frame(input int pre_high);
        int p;
        int fs0;
        fs0 = fs_cnt;
        repeat (pre_high) drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        p = pcnt;
        m_sy   = 0;
        m_oy   = 0;
        m_addr = 0;
        m_ovr  = 0;
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        chk("frame_start_count", fs_cnt, fs0 + 1);
        chk("frame_start_cycle", fs_cyc, p + 1);
        chk("overrun_cleared", 32'(overrun), 0);
    endtask

    task automatic end_frame();
        int p;
        int fd0;
        fd0 = fd_cnt;
        drive(1'b0, 1'b1, 8'h00);
        p = pcnt;
        repeat (2) drive(1'b0, 1'b1, 8'h00);
        chk("frame_done_count", fd_cnt, fd0 + 1);
        chk("frame_done_cycle", fd_cyc, p + 1);
        chk("frame_overrun", 32'(overrun), 32'(m_ovr));
        chk("scoreboard_empty", q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int pv0;
        int fs0;
        int fd0;
        int nl;
        int nb;

        v_sync = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge pclk);
        chk("rst_valid", 32'(pixel_valid), 0);
        chk("rst_pixel", 32'(pixel_out), 0);
        chk("rst_addr", 32'(pixel_addr), 0);
        chk("rst_xy", 32'({x_count, y_count}), 0);
        chk("rst_pulses", 32'({frame_start, frame_done}), 0);
        chk("rst_overrun", 32'(overrun), 0);
        reset_n = 1'b1;

        // v_sync already high at reset release
        start_frame(10);
        chk("sync_single_start", fs_cnt, 1);
        chk("sync_no_pixels", pv_cnt, 0);

        // full pure-red frame
        pv0 = pv_cnt;
        for (int l = 0; l < V; l++) send_line(2 * H, 1);
        end_frame();
        chk("red_strobes", pv_cnt - pv0, NPIX);
        chk("red_last_addr", last_addr, NPIX - 1);
        chk("red_rgb", 32'(last_rgb), 32'(3'b100));
        chk("red_lines", 32'(y_count), NLINES);

        // green then blue pair on one line
        start_frame(2);
        send_line(4, 2);
        end_frame();
`ifdef CAPTURE_DECIMATE_EN
        chk("colour_last", 32'(last_rgb), 32'(3'b010));
`else
        chk("colour_last", 32'(last_rgb), 32'(3'b001));
`endif

        // over-long line then odd-length line
        start_frame(2);
        send_line(2 * (H + 1), 0);
        send_line(3, 0);
        end_frame();
        chk("bound_overrun", 32'(overrun), 1);

        // randomized frames, including lines past both bounds
        for (int f = 0; f < 4; f++) begin
            start_frame(2);
            nl = $urandom_range(1, V + 2);
            for (int l = 0; l < nl; l++) begin
                nb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * H + 3) : 2 * H;
                send_line(nb, 0);
            end
            end_frame();
        end

        // enable dropped mid-frame: frame completes, no restart
        start_frame(2);
        for (int l = 0; l < V; l++) begin
            if (l == V / 2)
                enable = 1'b0;
            send_line(2 * H, 0);
        end
        end_frame();
        chk("endrop_last_addr", last_addr, NPIX - 1);
        fs0 = fs_cnt;
        pv0 = pv_cnt;
        repeat (3) drive(1'b0, 1'b1, 8'h00);
        repeat (5) drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'($urandom));
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        chk("endrop_no_start", fs_cnt, fs0);
        chk("endrop_no_pixel", pv_cnt, pv0);

        // reset in the middle of a frame
        enable = 1'b1;
        start_frame(3);
        send_line(2 * H, 0);
        send_line(2 * H, 0);
        fd0 = fd_cnt;
        @(negedge pclk);
        reset_n = 1'b0;
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        chk("midrst_valid", 32'(pixel_valid), 0);
        chk("midrst_y", 32'(y_count), 0);
        chk("midrst_addr", 32'(pixel_addr), 0);
        reset_n = 1'b1;
        repeat (2) drive(1'b0, 1'b1, 8'h00);
        chk("midrst_no_done", fd_cnt, fd0);
        q.delete();
        start_frame(3);
        send_line(2 * H, 0);
        end_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
